inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 153 +++++++++++++++
 tb/tb_inst_encoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I field encoder feeding a 2-entry {data, addr, err} output FIFO
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        restart,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam logic [6:0]  OP_R    = 7'h33;
  localparam logic [6:0]  OP_I    = 7'h13;
  localparam logic [6:0]  OP_L    = 7'h03;
  localparam logic [6:0]  OP_S    = 7'h23;
  localparam logic [6:0]  OP_LUI  = 7'h37;
  localparam logic [6:0]  OP_JAL  = 7'h6F;
  localparam logic [6:0]  OP_JALR = 7'h67;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM21_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM21_MAX = 32'sd1048574;

  logic [31:0] data_q [2];
  logic [31:0] data_d [2];
  logic [31:0] addr_q [2];
  logic [31:0] addr_d [2];
  logic [1:0]  err_q, err_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        active_q, active_d;

  logic signed [31:0] imm_s;
  logic               imm12_ok;
  logic [31:0]        enc_word;
  logic               enc_bad;
  logic               push, pop;

  assign imm_s    = $signed(in_imm);
  assign imm12_ok = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);

  always_comb begin
    enc_word = NOP_WORD;
    enc_bad  = 1'b0;
    case (in_opcode)
      OP_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      OP_I, OP_L, OP_JALR: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_bad  = !imm12_ok;
      end
      OP_S: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_bad  = !imm12_ok;
      end
      OP_LUI: begin
        enc_word = {in_imm[31:12], in_rd, in_opcode};
        enc_bad  = (in_imm[11:0] != 12'd0);
      end
      OP_JAL: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_bad  = (imm_s < IMM21_MIN) || (imm_s > IMM21_MAX) || in_imm[0];
      end
      default: enc_bad = 1'b1;
    endcase
    // Faulty words are replaced so the consumer never sees a malformed encoding
    if (enc_bad) enc_word = NOP_WORD;
  end

  // active_q keeps in_ready low until the first clock after reset release
  assign in_ready  = active_q && (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !restart;
  assign pop       = out_valid && out_ready && !restart;

  always_comb begin
    data_d    = data_q;
    addr_d    = addr_q;
    err_d     = err_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pc_d      = pc_q;
    err_cnt_d = err_cnt_q;
    active_d  = 1'b1;
    if (restart) begin
      wr_ptr_d  = 1'b0;
      rd_ptr_d  = 1'b0;
      count_d   = 2'd0;
      pc_d      = 32'd0;
      err_cnt_d = 8'd0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = enc_word;
        addr_d[wr_ptr_q] = pc_q;
        err_d[wr_ptr_q]  = enc_bad;
        wr_ptr_d         = ~wr_ptr_q;
        pc_d             = pc_q + 32'd4;
        if (enc_bad && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '{default: 32'd0};
      addr_q    <= '{default: 32'd0};
      err_q     <= 2'b00;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      pc_q      <= 32'd0;
      err_cnt_q <= 8'd0;
      active_q  <= 1'b0;
    end else begin
      data_q    <= data_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pc_q      <= pc_d;
      err_cnt_q <= err_cnt_d;
      active_q  <= active_d;
    end
  end

  assign out_data  = data_q[rd_ptr_q];
  assign out_addr  = addr_q[rd_ptr_q];
  assign out_err   = err_q[rd_ptr_q];
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed bench for inst_encoder with a queue-based reference model
module tb_inst_encoder;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        restart = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data, out_addr;
  logic        out_err;
  logic [7:0]  err_count;
  vec_t        cur;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(cur.op), .in_funct3(cur.f3), .in_funct7(cur.f7),
    .in_rd(cur.rd), .in_rs1(cur.rs1), .in_rs2(cur.rs2), .in_imm(cur.imm),
    .restart(restart), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    return v;
  endfunction

  function automatic void model_encode(input vec_t v, output logic [31:0] w, output logic e);
    int s;
    s = int'(v.imm);
    e = 1'b0;
    w = 32'd0;
    case (v.op)
      7'h33: w = {v.f7, v.rs2, v.rs1, v.f3, v.rd, v.op};
      7'h13, 7'h03, 7'h67: begin
        e = (s < -2048) || (s > 2047);
        w = {v.imm[11:0], v.rs1, v.f3, v.rd, v.op};
      end
      7'h23: begin
        e = (s < -2048) || (s > 2047);
        w = {v.imm[11:5], v.rs2, v.rs1, v.f3, v.imm[4:0], v.op};
      end
      7'h37: begin
        e = (v.imm[11:0] != 12'd0);
        w = {v.imm[31:12], v.rd, v.op};
      end
      7'h6F: begin
        e = (s < -(1 << 20)) || (s > (1 << 20) - 2) || (v.imm[0] == 1'b1);
        w = {v.imm[20], v.imm[10:1], v.imm[11], v.imm[19:12], v.rd, v.op};
      end
      default: e = 1'b1;
    endcase
    if (e) w = 32'h0000_0013;
  endfunction

  // Reference model: compare at negedge, then advance using the inputs the next posedge will see
  initial begin
    exp_t        q[$];
    exp_t        item;
    logic [31:0] pc = 32'd0;
    int          errs = 0;
    bit          active = 1'b0;
    bit          exp_ready, exp_valid;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        pc = 32'd0;
        errs = 0;
        active = 1'b0;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst out_addr", out_addr, 32'd0);
        chk("rst out_err", 32'(out_err), 32'd0);
        chk("rst err_count", 32'(err_count), 32'd0);
      end else begin
        exp_ready = active && (q.size() < 2);
        exp_valid = (q.size() != 0);
        chk("model in_ready", 32'(in_ready), 32'(exp_ready));
        chk("model out_valid", 32'(out_valid), 32'(exp_valid));
        chk("model err_count", 32'(err_count), 32'(errs));
        if (exp_valid) begin
          chk("model out_data", out_data, q[0].d);
          chk("model out_addr", out_addr, q[0].a);
          chk("model out_err", 32'(out_err), 32'(q[0].e));
        end
        if (restart) begin
          q.delete();
          pc = 32'd0;
          errs = 0;
        end else begin
          if (exp_valid && out_ready) void'(q.pop_front());
          if (in_valid && exp_ready) begin
            model_encode(cur, item.d, item.e);
            item.a = pc;
            q.push_back(item);
            pc = pc + 32'd4;
            if (item.e && errs < 255) errs++;
          end
        end
        active = 1'b1;
      end
    end
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL accept timeout: in_ready stayed 0, required 1");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input vec_t v);
    cur = v;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  vec_t table_v[$];

  initial begin
    cur = mk(7'h33, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("lit reset in_ready", 32'(in_ready), 32'd0);
    chk("lit reset out_valid", 32'(out_valid), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("lit in_ready after reset", 32'(in_ready), 32'd1);

    push(mk(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0));
    chk("lit add data", out_data, 32'h002081B3);
    chk("lit add addr", out_addr, 32'd0);
    chk("lit add err", 32'(out_err), 32'd0);

    do_restart();
    push(mk(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF));
    chk("lit addi data", out_data, 32'hFFF00093);
    chk("lit addi addr", out_addr, 32'd0);
    push(mk(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8));
    chk("lit sw data", out_data, 32'h0020A423);
    chk("lit sw addr", out_addr, 32'd4);

    do_restart();
    push(mk(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8));
    chk("lit jal data", out_data, 32'h008000EF);
    push(mk(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048));
    chk("lit addi2048 data", out_data, 32'h00000013);
    chk("lit addi2048 err", 32'(out_err), 32'd1);
    chk("lit addi2048 err_count", 32'(err_count), 32'd1);
    push(mk(7'h37, 3'd0, 7'd0, 5'd1, 5'd9, 5'd0, 32'h12345000));
    chk("lit lui data", out_data, 32'h123450B7);

    // backpressure: third push stalls until the consumer drains
    do_restart();
    out_ready = 1'b0;
    push(mk(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0));
    push(mk(7'h33, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0));
    chk("lit full in_ready", 32'(in_ready), 32'd0);
    cur = mk(7'h13, 3'd0, 7'd0, 5'd7, 5'd8, 5'd0, 32'd5);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("lit held in_ready", 32'(in_ready), 32'd0);
    chk("lit held out_addr", out_addr, 32'd0);
    out_ready = 1'b1;
    wait_accept();
    chk("lit third addr", out_addr, 32'd8);
    chk("lit third data", out_data, 32'h00540393);

    // restart beats a simultaneous push while full
    do_restart();
    out_ready = 1'b0;
    push(mk(7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1));
    push(mk(7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0));
    chk("lit pre-restart err_count", 32'(err_count), 32'd1);
    cur = mk(7'h33, 3'd0, 7'd0, 5'd2, 5'd2, 5'd2, 32'd0);
    in_valid = 1'b1;
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    in_valid = 1'b0;
    chk("lit restart out_valid", 32'(out_valid), 32'd0);
    chk("lit restart err_count", 32'(err_count), 32'd0);
    chk("lit restart in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    push(mk(7'h33, 3'd0, 7'd0, 5'd2, 5'd2, 5'd2, 32'd0));
    chk("lit post-restart addr", out_addr, 32'd0);

    // async reset with two words buffered
    out_ready = 1'b0;
    push(mk(7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0));
    chk("lit pre-reset out_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("lit async out_valid", 32'(out_valid), 32'd0);
    chk("lit async in_ready", 32'(in_ready), 32'd0);
    chk("lit async out_data", out_data, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    push(mk(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0));
    chk("lit post-reset addr", out_addr, 32'd0);

    // encoding and range boundaries, checked by the model with varied out_ready
    table_v.push_back(mk(7'h33, 3'd0, 7'h20, 5'd5, 5'd6, 5'd7, 32'd0));
    table_v.push_back(mk(7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2047));
    table_v.push_back(mk(7'h13, 3'd4, 7'd0, 5'd1, 5'd2, 5'd0, -32'sd2048));
    table_v.push_back(mk(7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, -32'sd2049));
    table_v.push_back(mk(7'h03, 3'd2, 7'd0, 5'd4, 5'd5, 5'd0, -32'sd4));
    table_v.push_back(mk(7'h67, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd100));
    table_v.push_back(mk(7'h23, 3'd2, 7'd0, 5'd0, 5'd3, 5'd4, -32'sd2048));
    table_v.push_back(mk(7'h23, 3'd0, 7'd0, 5'd0, 5'd3, 5'd4, 32'd2048));
    table_v.push_back(mk(7'h37, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'hABCDE000));
    table_v.push_back(mk(7'h37, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'h12345001));
    table_v.push_back(mk(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd1048576));
    table_v.push_back(mk(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1048574));
    table_v.push_back(mk(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1048576));
    table_v.push_back(mk(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3));
    table_v.push_back(mk(7'h0F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0));
    for (int i = 0; i < table_v.size(); i++) begin
      out_ready = (i % 3 != 2);
      push(table_v[i]);
    end
    out_ready = 1'b1;

    // err_count saturation
    do_restart();
    for (int i = 0; i < 258; i++) push(mk(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0));
    chk("lit err_count saturated", 32'(err_count), 32'd255);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

endmodule
